memory_instruction_queue: RTL and testbench
===========================================

MEMORY_INSTRUCTION_QUEUE -- requirements
Module: memory_instruction_queue

Interface
REQ-001 Parameter MEMORY_ADDRESS_BITS, default 15, is the address/stride field width.
REQ-002 Parameter SUPERSCALAR_LOG_WIDTH, default 2, gives SUPERSCALAR_WIDTH = 1<<SUPERSCALAR_LOG_WIDTH lanes.
REQ-003 Parameter DEPTH_LOG, default 3, gives DEPTH = 1<<DEPTH_LOG entries.
REQ-004 Derived: LANE_W = 3*MEMORY_ADDRESS_BITS+15; ENTRY_W = LANE_W*SUPERSCALAR_WIDTH+2.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous queue clear, same effect as reset on queue state.
REQ-008 in_we  input  1  push request from control unit (memory_instruction_we).
REQ-009 in_instruction  input  ENTRY_W  packed superscalar memory instruction word.
REQ-010 in_copy_count  input  SUPERSCALAR_LOG_WIDTH  lane count minus one (value c means c+1 lanes).
REQ-011 stall  output  1  back-pressure to control unit; high when occupancy >= DEPTH-2.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 occupancy  output  DEPTH_LOG+1  number of stored entries.
REQ-014 out_valid  output  1  a lane beat is presented.
REQ-015 out_ready  input  1  downstream APU accepts the beat.
REQ-016 out_lane  output  SUPERSCALAR_LOG_WIDTH  index of lane currently presented.
REQ-017 out_lane_data  output  LANE_W  lane slice in_instruction[out_lane*LANE_W +: LANE_W] of head entry.
REQ-018 out_flags  output  2  head entry bits [ENTRY_W-1:ENTRY_W-2], unchanged.
REQ-019 out_last  output  1  current beat is the final lane of the head entry.
REQ-020 overflow  output  1  sticky error: push attempted while full.

Function
REQ-021 Storage: DEPTH-entry circular buffer of {in_instruction, in_copy_count}, write and read pointers DEPTH_LOG bits, wrapping modulo DEPTH.
REQ-022 Push: in_we high and not full -> entry written at write pointer, pointer +1, occupancy +1 at next edge.
REQ-023 Push while full is dropped, storage unchanged, overflow set to 1 and held until reset.
REQ-024 Push into empty queue -> out_valid high the following cycle (one-cycle latency), out_lane = 0.
REQ-025 States: EMPTY (occupancy 0, out_valid 0) and ISSUE (occupancy > 0, out_valid 1); lane counter valid only in ISSUE.
REQ-026 Beat transfer occurs when out_valid and out_ready both high; out_lane_data/out_flags/out_lane stable while out_valid high and out_ready low.
REQ-027 Transfer with out_lane < stored copy_count -> lane counter +1; entry retained.
REQ-028 Transfer with out_lane == stored copy_count (out_last) -> entry popped, read pointer +1, lane counter to 0.
REQ-029 out_last = out_valid and (out_lane == stored copy_count of head).
REQ-030 Simultaneous push and pop in one cycle: both take effect, occupancy unchanged; allowed when full only if the pop completes, otherwise push dropped per REQ-023.
REQ-031 After pop, ISSUE continues with next entry lane 0 without bubble if occupancy remains > 0; else EMPTY.
REQ-032 stall and full are combinational from the registered occupancy.
REQ-033 flush: pointers, occupancy, lane counter to 0, EMPTY; any same-cycle push ignored; overflow unaffected.

Reset
REQ-034 reset: occupancy 0, pointers 0, lane counter 0, state EMPTY, overflow 0, out_valid 0, stall 0, full 0, out_last 0.
REQ-035 reset mid-issue discards all entries including partially issued head; storage contents need not be cleared.
REQ-036 reset has priority over flush, in_we and out_ready.

Structure
REQ-037 LANE_W/ENTRY_W computation and the lane field layout {is_load, target, height, width, zero_flag, skip_flag, addr, stridex, stridey, daddr, dstridex, dstridey} belong in the shared package used by decoder and control_unit.
REQ-038 One sub-module natural: sync_fifo (parameterised width/depth, push/pop/full/empty/count); lane sequencer lives in memory_instruction_queue.

Verification
REQ-039 Push one entry copy_count=3, out_ready=1 -> beats lanes 0,1,2,3 on four consecutive cycles, out_last only on lane 3, then out_valid 0.
REQ-040 Push 8 entries copy_count=0, out_ready=0 -> stall high after 6th, full after 8th; 9th push sets overflow, occupancy stays 8.
REQ-041 Full queue, head copy_count=0, out_ready=1 and in_we=1 same cycle -> pop and push both occur, occupancy stays 8, overflow stays 0.
REQ-042 Head copy_count=2, out_ready toggled 1,0,1,0,1 -> lane data held during 0 cycles, lanes 0,1,2 delivered in order, pop after lane 2.
REQ-043 Three entries queued, reset during lane 1 of head -> next cycle occupancy 0, out_valid 0; fresh push issues lane 0 one cycle later.
REQ-044 Pointer wrap: 20 push/pop pairs with distinct addr fields -> outputs in push order, no loss or duplication.

Source files
------------

// File: rtl/memory_instruction_queue_pkg.sv
// Shared definitions for the memory instruction path: lane/entry width helpers,
// the lane field layout used by decoder and control_unit, and queue state codes.
package memory_instruction_queue_pkg;

   localparam int DEFAULT_ADDR_BITS = 15;

   function automatic int laneWidth(input int addrBits);
      return 3 * addrBits + 15;
   endfunction

   function automatic int entryWidth(input int addrBits, input int logWidth);
      return laneWidth(addrBits) * (1 << logWidth) + 2;
   endfunction

   // Lane field layout at the default address width (60 bits, MSB first).
   typedef struct packed {
      logic                         is_load;
      logic                         target;
      logic [2:0]                   height;
      logic [2:0]                   width;
      logic                         zero_flag;
      logic                         skip_flag;
      logic [DEFAULT_ADDR_BITS-1:0] addr;
      logic [4:0]                   stridex;
      logic [4:0]                   stridey;
      logic [DEFAULT_ADDR_BITS-1:0] daddr;
      logic [4:0]                   dstridex;
      logic [4:0]                   dstridey;
   } lane_fields_t;

   localparam int LANE_FIELDS_W = $bits(lane_fields_t);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/memory_instruction_queue_sync_fifo.sv
// Parameterised synchronous FIFO with combinational head read, used as the
// entry store of the memory instruction queue.
module memory_instruction_queue_sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [WIDTH-1:0]     wdata_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [DEPTH_LOG:0]   count_o
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [WIDTH-1:0]     memQ [DEPTH];
   logic [DEPTH_LOG-1:0] wrPtrQ, wrPtrD;
   logic [DEPTH_LOG-1:0] rdPtrQ, rdPtrD;
   logic [DEPTH_LOG:0]   countQ, countD;
   logic                 doPush, doPop;

   assign full_o  = (countQ == (DEPTH_LOG+1)'(DEPTH));
   assign empty_o = (countQ == '0);
   assign count_o = countQ;
   assign rdata_o = memQ[rdPtrQ];

   // A push into a full FIFO is accepted only when the same-cycle pop frees a slot.
   assign doPop  = pop_i && !empty_o && !clear_i;
   assign doPush = push_i && (!full_o || doPop) && !clear_i;

   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      countD = countQ;
      if (clear_i) begin
         wrPtrD = '0;
         rdPtrD = '0;
         countD = '0;
      end else begin
         if (doPush) wrPtrD = wrPtrQ + 1'b1;
         if (doPop)  rdPtrD = rdPtrQ + 1'b1;
         case ({doPush, doPop})
            2'b10:   countD = countQ + 1'b1;
            2'b01:   countD = countQ - 1'b1;
            default: countD = countQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         countQ <= countD;
      end
   end

   // Storage is deliberately left without reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (doPush && !reset) memQ[wrPtrQ] <= wdata_i;
   end

endmodule

// File: rtl/memory_instruction_queue.sv
// Queue of superscalar memory instructions between control unit and APU; each
// stored entry is issued downstream one lane per beat.
module memory_instruction_queue
   import memory_instruction_queue_pkg::*;
#(
   parameter int MEMORY_ADDRESS_BITS   = 15,
   parameter int SUPERSCALAR_LOG_WIDTH = 2,
   parameter int DEPTH_LOG             = 3,
   localparam int LANE_W  = laneWidth(MEMORY_ADDRESS_BITS),
   localparam int ENTRY_W = entryWidth(MEMORY_ADDRESS_BITS, SUPERSCALAR_LOG_WIDTH)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             in_we,
   input  logic [ENTRY_W-1:0]               in_instruction,
   input  logic [SUPERSCALAR_LOG_WIDTH-1:0] in_copy_count,
   output logic                             stall,
   output logic                             full,
   output logic [DEPTH_LOG:0]               occupancy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SUPERSCALAR_LOG_WIDTH-1:0] out_lane,
   output logic [LANE_W-1:0]                out_lane_data,
   output logic [1:0]                       out_flags,
   output logic                             out_last,
   output logic                             overflow
);

   localparam int DEPTH  = 1 << DEPTH_LOG;
   localparam int SLW    = SUPERSCALAR_LOG_WIDTH;
   localparam int FIFO_W = ENTRY_W + SLW;

   logic [FIFO_W-1:0]  headWord;
   logic [ENTRY_W-1:0] headInstr;
   logic [SLW-1:0]     headCount;
   logic               fifoFull, fifoEmpty;
   logic [DEPTH_LOG:0] fifoCount;
   logic [DEPTH_LOG:0] nextCount;

   logic [0:0]     stateQ, stateD;
   logic [SLW-1:0] laneQ, laneD;
   logic           overflowQ, overflowD;
   logic           beatFire, popFire, pushFire;

   memory_instruction_queue_sync_fifo #(
      .WIDTH    (FIFO_W),
      .DEPTH_LOG(DEPTH_LOG)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .clear_i(flush),
      .push_i (pushFire),
      .pop_i  (popFire),
      .wdata_i({in_instruction, in_copy_count}),
      .rdata_o(headWord),
      .full_o (fifoFull),
      .empty_o(fifoEmpty),
      .count_o(fifoCount)
   );

   assign headInstr = headWord[FIFO_W-1:SLW];
   assign headCount = headWord[SLW-1:0];

   assign out_valid     = (stateQ == ST_ISSUE) && !fifoEmpty;
   assign out_lane      = laneQ;
   assign out_last      = out_valid && (laneQ == headCount);
   assign out_lane_data = headInstr[int'(laneQ) * LANE_W +: LANE_W];
   assign out_flags     = headInstr[ENTRY_W-1 -: 2];

   assign occupancy = fifoCount;
   assign full      = fifoFull;
   assign stall     = (fifoCount >= (DEPTH_LOG+1)'(DEPTH - 2));
   assign overflow  = overflowQ;

   assign beatFire = out_valid && out_ready;
   assign popFire  = beatFire && out_last;
   assign pushFire = in_we && !flush && (!fifoFull || popFire);

   assign nextCount = fifoCount + (DEPTH_LOG+1)'(pushFire) - (DEPTH_LOG+1)'(popFire);

   // The lane counter walks the head entry and restarts at lane 0 on every pop,
   // so the next entry issues without a bubble.
   always_comb begin
      stateD    = stateQ;
      laneD     = laneQ;
      overflowD = overflowQ | (in_we && !flush && fifoFull && !popFire);
      if (flush) begin
         stateD = ST_EMPTY;
         laneD  = '0;
      end else begin
         stateD = (nextCount != '0) ? ST_ISSUE : ST_EMPTY;
         if (beatFire) laneD = out_last ? '0 : laneQ + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= ST_EMPTY;
         laneQ     <= '0;
         overflowQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         laneQ     <= laneD;
         overflowQ <= overflowD;
      end
   end

endmodule

// File: tb/tb_memory_instruction_queue.sv
// Directed bench for memory_instruction_queue: lane issue, back-pressure,
// overflow, push/pop when full, reset/flush and pointer wrap.
module tb_memory_instruction_queue;

   localparam int LANE_W  = 60;
   localparam int ENTRY_W = 242;

   logic               clk;
   logic               reset;
   logic               flush;
   logic               in_we;
   logic [ENTRY_W-1:0] in_instruction;
   logic [1:0]         in_copy_count;
   logic               stall;
   logic               full;
   logic [3:0]         occupancy;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_lane;
   logic [LANE_W-1:0]  out_lane_data;
   logic [1:0]         out_flags;
   logic               out_last;
   logic               overflow;

   int assertCount = 0;
   int failCount   = 0;

   memory_instruction_queue dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_we         (in_we),
      .in_instruction(in_instruction),
      .in_copy_count (in_copy_count),
      .stall         (stall),
      .full          (full),
      .occupancy     (occupancy),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_lane      (out_lane),
      .out_lane_data (out_lane_data),
      .out_flags     (out_flags),
      .out_last      (out_last),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [LANE_W-1:0] laneVal(input int tagv, input int lane);
      return {16'hC0DE, 28'(tagv), 16'(lane)};
   endfunction

   function automatic logic [ENTRY_W-1:0] makeInstr(input logic [1:0] flags, input int tagv);
      logic [ENTRY_W-1:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) w[i*LANE_W +: LANE_W] = laneVal(tagv, i);
      w[ENTRY_W-1 -: 2] = flags;
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input int tagv, input logic [1:0] cc, input logic ready);
      in_we          = we;
      in_instruction = makeInstr(2'(tagv), tagv);
      in_copy_count  = cc;
      out_ready      = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int expTags [8];

   initial begin
      reset = 1'b1; flush = 1'b0;
      applyStimulus(1'b0, 0, 2'd0, 1'b0);
      tick(); tick();
      reset = 1'b0;

      checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_stall", 64'(stall), 64'd0);
      checkOutput("reset_full", 64'(full), 64'd0);
      checkOutput("reset_last", 64'(out_last), 64'd0);
      checkOutput("reset_overflow", 64'(overflow), 64'd0);

      // Four-lane entry drains one lane per cycle.
      applyStimulus(1'b1, 1, 2'd3, 1'b1);
      tick();
      in_we = 1'b0;
      for (int l = 0; l < 4; l++) begin
         checkOutput($sformatf("issue_valid_l%0d", l), 64'(out_valid), 64'd1);
         checkOutput($sformatf("issue_lane_l%0d", l), 64'(out_lane), 64'(l));
         checkOutput($sformatf("issue_data_l%0d", l), 64'(out_lane_data), 64'(laneVal(1, l)));
         checkOutput($sformatf("issue_last_l%0d", l), 64'(out_last), 64'(l == 3));
         checkOutput($sformatf("issue_flags_l%0d", l), 64'(out_flags), 64'd1);
         tick();
      end
      checkOutput("issue_done_valid", 64'(out_valid), 64'd0);
      checkOutput("issue_done_occ", 64'(occupancy), 64'd0);

      // Fill with back-pressure, then overflow.
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 9 + k, 2'd0, 1'b0);
         tick();
         checkOutput($sformatf("fill_occ_%0d", k), 64'(occupancy), 64'(k));
         checkOutput($sformatf("fill_stall_%0d", k), 64'(stall), 64'(k >= 6));
         checkOutput($sformatf("fill_full_%0d", k), 64'(full), 64'(k == 8));
      end
      applyStimulus(1'b1, 99, 2'd0, 1'b0);
      tick();
      in_we = 1'b0;
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_occ", 64'(occupancy), 64'd8);
      checkOutput("ovf_head", 64'(out_lane_data), 64'(laneVal(10, 0)));
      tick();
      checkOutput("ovf_sticky", 64'(overflow), 64'd1);

      // Simultaneous push and pop on a full queue.
      doReset();
      checkOutput("rst2_overflow", 64'(overflow), 64'd0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 10 + k, 2'd0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 20, 2'd0, 1'b1);
      tick();
      in_we = 1'b0;
      checkOutput("pp_occ", 64'(occupancy), 64'd8);
      checkOutput("pp_overflow", 64'(overflow), 64'd0);
      checkOutput("pp_full", 64'(full), 64'd1);
      expTags = '{11, 12, 13, 14, 15, 16, 17, 20};
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("drain_valid_%0d", k), 64'(out_valid), 64'd1);
         checkOutput($sformatf("drain_data_%0d", k), 64'(out_lane_data), 64'(laneVal(expTags[k], 0)));
         tick();
      end
      checkOutput("drain_empty", 64'(out_valid), 64'd0);

      // Head with three lanes under toggling ready.
      applyStimulus(1'b1, 30, 2'd2, 1'b0);
      tick();
      in_we = 1'b0;
      checkOutput("tog_l0", 64'(out_lane_data), 64'(laneVal(30, 0)));
      out_ready = 1'b1; tick();
      checkOutput("tog_l1", 64'(out_lane_data), 64'(laneVal(30, 1)));
      out_ready = 1'b0; tick();
      checkOutput("tog_hold1_data", 64'(out_lane_data), 64'(laneVal(30, 1)));
      checkOutput("tog_hold1_lane", 64'(out_lane), 64'd1);
      out_ready = 1'b1; tick();
      checkOutput("tog_l2", 64'(out_lane_data), 64'(laneVal(30, 2)));
      checkOutput("tog_l2_last", 64'(out_last), 64'd1);
      out_ready = 1'b0; tick();
      checkOutput("tog_hold2_data", 64'(out_lane_data), 64'(laneVal(30, 2)));
      checkOutput("tog_hold2_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1; tick();
      checkOutput("tog_popped", 64'(out_valid), 64'd0);

      // Reset in the middle of issuing the head.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 40 + k, 2'd3, 1'b0);
         tick();
      end
      in_we = 1'b0;
      out_ready = 1'b1; tick();
      checkOutput("mid_lane1", 64'(out_lane), 64'd1);
      reset = 1'b1; tick();
      reset = 1'b0; out_ready = 1'b0;
      checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
      checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b1, 50, 2'd1, 1'b0);
      tick();
      in_we = 1'b0;
      checkOutput("fresh_valid", 64'(out_valid), 64'd1);
      checkOutput("fresh_lane", 64'(out_lane), 64'd0);
      checkOutput("fresh_data", 64'(out_lane_data), 64'(laneVal(50, 0)));

      // Flush clears the queue and ignores the concurrent push.
      applyStimulus(1'b1, 52, 2'd0, 1'b0);
      flush = 1'b1; tick();
      flush = 1'b0; in_we = 1'b0;
      checkOutput("flush_occ", 64'(occupancy), 64'd0);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_overflow", 64'(overflow), 64'd0);

      // Streaming push/pop pairs wrap the pointers several times.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 60 + k, 2'd0, 1'b1);
         tick();
         checkOutput($sformatf("wrap_data_%0d", k), 64'(out_lane_data), 64'(laneVal(60 + k, 0)));
         checkOutput($sformatf("wrap_occ_%0d", k), 64'(occupancy), 64'd1);
      end
      in_we = 1'b0;
      tick();
      checkOutput("wrap_end_valid", 64'(out_valid), 64'd0);
      checkOutput("wrap_end_occ", 64'(occupancy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
